instr_fetch_ctrl: RTL and testbench

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

---
 rtl/instr_fetch_ctrl_pkg.sv | 15 +
 rtl/instr_fetch_ctrl_fifo.sv | 36 +++
 rtl/instr_fetch_ctrl.sv | 74 +++++++
 tb/tb_instr_fetch_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/instr_fetch_ctrl_pkg.sv
// instr_fetch_ctrl_pkg: shared FSM states, fetch-entry type and PC step for the fetch controller.
// The TRAP state exists only when FETCH_MISALIGN_TRAP_EN is defined.
package instr_fetch_ctrl_pkg;
    localparam int XLEN    = 32;
    localparam int PC_STEP = 4;
`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {RUN, HALTED, TRAP} state_t;
`else
    typedef enum logic [0:0] {RUN, HALTED} state_t;
`endif
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_ctrl_fifo.sv
// fetch_fifo: registered fetch buffer of {pc, instr} pairs with synchronous flush.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [WIDTH-1:0]        push_pc,
    input  logic [WIDTH-1:0]        push_instr,
    output logic [$clog2(DEPTH):0]  count,
    output logic [WIDTH-1:0]        head_pc,
    output logic [WIDTH-1:0]        head_instr
);
    localparam int AW = $clog2(DEPTH);
    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {push_pc, push_instr};
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    // An empty buffer presents zeros so the head is clean after reset and flush.
    assign {head_pc, head_instr} = (count != '0) ? mem[rd_ptr] : '0;
endmodule

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: PC sequencer feeding a fetch buffer, with redirect, halt and drain.
// Define FETCH_MISALIGN_TRAP_EN to trap on misaligned redirects instead of masking them.
module instr_fetch_ctrl
    import instr_fetch_ctrl_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               DEPTH    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_rd,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             halt_req,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [WIDTH-1:0] id_instr,
    output logic [WIDTH-1:0] id_pc,
    output logic             halted,
    output logic             trap
);
    localparam int CW = $clog2(DEPTH) + 1;
    state_t           state, next_state;
    logic [WIDTH-1:0] pc, target;
    logic [CW-1:0]    count;
    logic             push, pop;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned;
    assign target     = redirect_pc;
    assign misaligned = redirect_valid && redirect_pc[1:0] != 2'b00;
    assign trap       = state == TRAP;
`else
    assign target = redirect_pc & ~WIDTH'(3);
    assign trap   = 1'b0;
`endif
    // A redirect outranks both buffer ports; the flush empties the buffer instead.
    always_comb begin
        next_state = state;
        pop  = id_valid && id_ready && !redirect_valid;
        push = state == RUN && !halt_req && !redirect_valid && (count < CW'(DEPTH) || pop);
        if (state == RUN && halt_req && count == '0) next_state = HALTED;
        if (state == HALTED && !halt_req) next_state = RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (misaligned && state != TRAP) next_state = TRAP;
`endif
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
            pc    <= RESET_PC;
        end else begin
            state <= next_state;
            if (redirect_valid) pc <= target;
            else if (push) pc <= pc + WIDTH'(PC_STEP);
        end
    end
    fetch_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_pc   (pc),
        .push_instr(imem_rd),
        .count     (count),
        .head_pc   (id_pc),
        .head_instr(id_instr)
    );
    assign imem_addr = pc;
    assign id_valid  = count != '0;
    assign halted    = state == HALTED;
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: scoreboard bench; a queue-based fetch model predicts each cycle's outputs.
module tb_instr_fetch_ctrl;
    import instr_fetch_ctrl_pkg::*;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int S_RUN = 0, S_HALT = 1, S_TRAP = 2;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    logic        clk = 1'b0, rst_n = 1'b0, redirect_valid = 1'b0, halt_req = 1'b0, id_ready = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr, imem_rd, id_instr, id_pc;
    logic        id_valid, halted, trap;

    always #5 clk = ~clk;

    instr_fetch_ctrl #(.WIDTH(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rd(imem_rd),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
        .halted(halted), .trap(trap)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h002081B3;
            32'h4:   return 32'h403202B3;
            32'h8:   return 32'h00B6F663;
            32'h30:  return 32'h00110293;
            default: return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
        endcase
    endfunction
    assign imem_rd = mem_word(imem_addr);

    typedef struct {
        logic         valid;
        fetch_entry_t head;
        logic         halted;
        logic         trap;
        logic [31:0]  addr;
    } exp_t;
    exp_t        exp_q[$];
    logic [31:0] buf_m[$];
    logic [31:0] pc_m;
    int          st_m;
    bit          model_ok = 0;
    int          checks = 0, failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the DUT against the oldest prediction every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("id_valid", 32'(id_valid), 32'(e.valid));
                if (e.valid) begin
                    check("id_pc", id_pc, e.head.pc);
                    check("id_instr", id_instr, e.head.instr);
                end
                check("halted", 32'(halted), 32'(e.halted));
                check("trap", 32'(trap), 32'(e.trap));
                check("imem_addr", imem_addr, e.addr);
            end
        end
    end

    // One cycle: record the predicted outputs, drive inputs, advance the model.
    task automatic step(input logic r, input logic rv, input logic [31:0] rp,
                        input logic hr, input logic rdy);
        exp_t e;
        int   sz, ns;
        bit   pop, push;
        @(negedge clk);
        if (model_ok) begin
            e.valid      = buf_m.size() != 0;
            e.head.pc    = e.valid ? buf_m[0] : 32'h0;
            e.head.instr = mem_word(e.head.pc);
            e.halted     = st_m == S_HALT;
            e.trap       = st_m == S_TRAP;
            e.addr       = pc_m;
            exp_q.push_back(e);
        end
        rst_n = r; redirect_valid = rv; redirect_pc = rp; halt_req = hr; id_ready = rdy;
        if (!r) begin
            pc_m = RESET_PC; buf_m.delete(); st_m = S_RUN; model_ok = 1;
        end else if (model_ok) begin
            sz = buf_m.size();
            ns = st_m;
            if (st_m == S_RUN && hr && sz == 0) ns = S_HALT;
            if (st_m == S_HALT && !hr) ns = S_RUN;
            if (TRAP_EN && rv && rp[1:0] != 2'b00 && st_m != S_TRAP) ns = S_TRAP;
            if (rv) begin
                buf_m.delete();
                pc_m = TRAP_EN ? rp : {rp[31:2], 2'b00};
            end else begin
                pop  = sz != 0 && rdy;
                push = st_m == S_RUN && !hr && (sz < DEPTH || pop);
                if (pop) void'(buf_m.pop_front());
                if (push) begin
                    buf_m.push_back(pc_m);
                    pc_m = pc_m + 32'd4;
                end
            end
            st_m = ns;
        end
    endtask

    initial begin
        bit          hr = 0, rv;
        logic [31:0] rp;
        repeat (2) step(0, 0, 0, 0, 0);
        repeat (4) step(1, 0, 0, 0, 1);            // streaming 0, 4, 8
        step(0, 0, 0, 0, 0);
        repeat (5) step(1, 0, 0, 0, 0);            // stall: buffer saturates, pc stops at 8
        step(1, 1, 32'h30, 0, 0);                  // redirect while full
        repeat (3) step(1, 0, 0, 0, 1);
        repeat (3) step(1, 0, 0, 0, 0);            // refill two entries
        repeat (5) step(1, 0, 0, 1, 1);            // halt: drain then HALTED
        step(1, 1, 32'h40, 1, 0);                  // redirect while halted
        repeat (2) step(1, 0, 0, 1, 1);
        repeat (4) step(1, 0, 0, 0, 1);            // resume
        step(1, 1, 32'hFFFF_FFF8, 0, 1);           // wrap past the top of memory
        repeat (5) step(1, 0, 0, 0, 1);
        step(1, 1, 32'h32, 0, 1);                  // misaligned redirect
        repeat (4) step(1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        repeat (1500) begin
            if ($urandom_range(0, 19) == 0) hr = !hr;
            rv = $urandom_range(0, 15) == 0;
            rp = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : 32'h0;
            rp = rp | {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            if ($urandom_range(0, 5) == 0) rp[1:0] = 2'($urandom_range(1, 3));
            step($urandom_range(0, 59) != 0, rv, rp, hr, $urandom_range(0, 3) != 0);
        end
        repeat (3) step(1, 0, 0, 0, 1);
        @(negedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
